muldiv_issuer: RTL and testbench



---
 rtl/muldiv_issuer.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_issuer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issuer.sv
// muldiv_issuer: EX-stage front end for the iterative 32-bit mult/div engine.
// It takes one RV32M op, holds the pipeline, and sends unsigned magnitudes to the engine.
// It then applies the sign fix-up and selects the result word. Divide-by-zero and
// signed overflow are answered directly, without starting the engine.
//
// Handshake semantics:
//   op_valid  - the op and its operands stay stable in EX while stall=1. An op is taken in
//               IDLE when op_valid && !kill.
//   md_valid  - a one-cycle start pulse in ISSUE. md_in_a/md_in_b/md_mode are held from
//               ISSUE until the op leaves WAIT.
//   md_ready  - a one-cycle result strobe from the engine. It is only looked at in WAIT
//               and DRAIN.
//   result_valid / timeout_err - one-cycle pulses. result is held between pulses.
module muldiv_issuer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        kill,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout_err,
    output logic        md_valid,
    output logic        md_mode,
    output logic [31:0] md_in_a,
    output logic [31:0] md_in_b,
    input  logic        md_ready,
    input  logic [63:0] md_out,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    funct_q;
    logic          neg_a_q, neg_b_q;
    logic [CW-1:0] cnt_q;

    logic          accept, load_op, load_res, timeout_hit;
    logic          sgn_a, sgn_b, neg_a, neg_b, is_div, div_zero, div_ovf, special;
    logic [31:0]   mag_a, mag_b, special_res, fixed_res, quo_fix, rem_fix;
    logic [63:0]   prod_fix;

    assign dbg_state   = state_q;
    assign accept      = (state_q == S_IDLE) && op_valid && !kill;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT));

    // Operand decode: signedness, magnitudes and the divide special cases
    always_comb begin
        is_div      = op_funct[2];
        sgn_a       = (op_funct == 3'd1) || (op_funct == 3'd2) ||
                      (op_funct == 3'd4) || (op_funct == 3'd6);
        sgn_b       = (op_funct == 3'd1) || (op_funct == 3'd4) || (op_funct == 3'd6);
        neg_a       = sgn_a && op_a[31];
        neg_b       = sgn_b && op_b[31];
        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
        mag_a       = neg_a ? (32'd0 - op_a) : op_a;
        mag_b       = neg_b ? (32'd0 - op_b) : op_b;
        div_zero    = is_div && (op_b == 32'd0);
        div_ovf     = is_div && !op_funct[0] && (op_a == 32'h8000_0000) &&
                      (op_b == 32'hFFFF_FFFF);
        special     = div_zero || div_ovf;
        special_res = 32'd0;
        if (div_zero)
            special_res = op_funct[1] ? op_a : 32'hFFFF_FFFF;
        else
            special_res = op_funct[1] ? 32'd0 : 32'h8000_0000;
    end

    // Result fix-up from the engine output and the signs latched at accept
    always_comb begin
        prod_fix  = (neg_a_q ^ neg_b_q) ? (64'd0 - md_out) : md_out;
        quo_fix   = (neg_a_q ^ neg_b_q) ? (32'd0 - md_out[31:0]) : md_out[31:0];
        rem_fix   = neg_a_q ? (32'd0 - md_out[63:32]) : md_out[63:32];
        fixed_res = rem_fix;
        case (funct_q)
            3'd0:                fixed_res = md_out[31:0];
            3'd1, 3'd2, 3'd3:    fixed_res = prod_fix[63:32];
            3'd4, 3'd5:          fixed_res = quo_fix;
            default:             fixed_res = rem_fix;
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        md_valid     = 1'b0;
        result_valid = 1'b0;
        timeout_err  = 1'b0;
        load_op      = 1'b0;
        load_res     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    load_op = 1'b1;
                    state_d = special ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                stall = 1'b1;
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    md_valid = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = !kill;
                if (md_ready) begin
                    if (kill) begin
                        state_d = S_IDLE;
                    end else begin
                        load_res = 1'b1;
                        state_d  = S_DONE;
                    end
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end else if (kill) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_d      = S_IDLE;
            end
            S_DRAIN: begin
                stall = op_valid;
                if (md_ready) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Timeout counter: cleared on entry to WAIT/DRAIN, counts while there
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (((state_d == S_WAIT) || (state_d == S_DRAIN)) && (state_d != state_q))
            cnt_q <= '0;
        else if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !timeout_hit)
            cnt_q <= cnt_q + CW'(1);
    end

    // Op latch at accept; result register loaded by the special path or the engine
    always_ff @(posedge clk) begin
        if (rst) begin
            funct_q <= 3'd0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            md_mode <= 1'b0;
            md_in_a <= 32'd0;
            md_in_b <= 32'd0;
            result  <= 32'd0;
        end else begin
            if (load_op) begin
                funct_q <= op_funct;
                neg_a_q <= neg_a;
                neg_b_q <= neg_b;
                md_mode <= is_div;
                md_in_a <= mag_a;
                md_in_b <= mag_b;
                if (special) result <= special_res;
            end
            if (load_res) result <= fixed_res;
        end
    end

endmodule

// File: tb/tb_muldiv_issuer.sv
// tb_muldiv_issuer: directed bench for muldiv_issuer, with a behavioural 32-iteration
// engine model and a scoreboard of expected rd values.
module tb_muldiv_issuer;

    localparam int TIMEOUT = 64;
    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_funct = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        kill = 1'b0;
    logic        md_ready = 1'b0;
    logic [63:0] md_out = 64'd0;
    logic        stall, result_valid, timeout_err, md_valid, md_mode;
    logic [31:0] result, md_in_a, md_in_b;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    // engine model state
    bit          eng_en = 1'b1;
    bit          eng_busy = 1'b0;
    int          ready_cyc = 0;
    int          md_valid_cnt = 0;
    int          md_valid_cyc = 0;
    logic [31:0] cap_a = 32'd0;
    logic [31:0] cap_b = 32'd0;
    logic        cap_mode = 1'b0;

    muldiv_issuer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_funct(op_funct),
        .op_a(op_a), .op_b(op_b), .kill(kill), .stall(stall), .result(result),
        .result_valid(result_valid), .timeout_err(timeout_err), .md_valid(md_valid),
        .md_mode(md_mode), .md_in_a(md_in_a), .md_in_b(md_in_b), .md_ready(md_ready),
        .md_out(md_out), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // engine model: md_ready strobes 33 cycles after the md_valid pulse
    initial begin
        forever begin
            @(posedge clk);
            #1;
            md_ready = eng_busy && eng_en && (cyc == ready_cyc);
            if (eng_busy && (cyc >= ready_cyc)) eng_busy = 1'b0;
            @(negedge clk);
            if (rst) begin
                eng_busy = 1'b0;
            end else if (md_valid) begin
                md_valid_cnt++;
                md_valid_cyc = cyc;
                cap_a    = md_in_a;
                cap_b    = md_in_b;
                cap_mode = md_mode;
                eng_busy = 1'b1;
                ready_cyc = cyc + 33;
                if (!cap_mode)      md_out = {32'd0, cap_a} * {32'd0, cap_b};
                else if (cap_b != 0) md_out = {cap_a % cap_b, cap_a / cap_b};
                else                md_out = {cap_a, 32'hFFFF_FFFF};
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // reference rd value from RV32M arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            F_MUL:    begin p = ua * ub; return p[31:0]; end
            F_MULH:   begin p = sa * sb; return p[63:32]; end
            F_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            F_MULHU:  begin p = ua * ub; return p[63:32]; end
            F_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM:    begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return $signed(a) % $signed(b);
            end
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] exp_mag(input logic [2:0] f, input logic [31:0] x,
                                            input bit is_a);
        bit sgn;
        sgn = is_a ? ((f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM))
                   : ((f == F_MULH) || (f == F_DIV) || (f == F_REM));
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && ((b == 0) || (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
            return 1;
        return 35;
    endfunction

    // drive one op like the pipeline would (held while stall) and check it end to end;
    // called just after a posedge, which is cycle T of the op
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
        int base_mv, t0, k, exp_mv;
        bit got, stall_now;
        base_mv = md_valid_cnt;
        t0      = cyc;
        got     = 1'b0;
        k       = 0;
        exp_q.push_back(ref_result(f, a, b));
        op_valid = 1'b1; op_funct = f; op_a = a; op_b = b;
        while (!got && (k < 200)) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1;
                chk({tag, " latency"}, 64'(k), 64'(exp_lat));
                chk({tag, " result"}, 64'(result), 64'(exp_q.pop_front()));
                chk({tag, " stall in done"}, 64'(stall), 64'd0);
            end else if (k < exp_lat) begin
                chk({tag, " stall"}, 64'(stall), 64'd1);
            end
            stall_now = stall;
            @(posedge clk);
            #1;
            if (!stall_now) op_valid = 1'b0;
            k++;
        end
        op_valid = 1'b0;
        if (!got) begin
            chk({tag, " result_valid seen"}, 64'd0, 64'd1);
            void'(exp_q.pop_back());
        end
        exp_mv = (exp_lat >= 34) ? 1 : 0;
        chk({tag, " md_valid count"}, 64'(md_valid_cnt - base_mv), 64'(exp_mv));
        if (exp_mv == 1) begin
            chk({tag, " md_valid cycle"}, 64'(md_valid_cyc - t0), 64'(exp_lat - 34));
            chk({tag, " md_in_a"}, 64'(cap_a), 64'(exp_mag(f, a, 1'b1)));
            chk({tag, " md_in_b"}, 64'(cap_b), 64'(exp_mag(f, b, 1'b0)));
            chk({tag, " md_mode"}, 64'(cap_mode), 64'(f[2]));
        end
        @(negedge clk);
        chk({tag, " idle after done"}, 64'({result_valid, stall}), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " stall"}, 64'(stall), 64'd0);
        chk({tag, " result"}, 64'(result), 64'd0);
        chk({tag, " result_valid"}, 64'(result_valid), 64'd0);
        chk({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
        chk({tag, " md_valid"}, 64'(md_valid), 64'd0);
        chk({tag, " md_mode"}, 64'(md_mode), 64'd0);
        chk({tag, " md_in_a"}, 64'(md_in_a), 64'd0);
        chk({tag, " md_in_b"}, 64'(md_in_b), 64'd0);
        chk({tag, " state"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        int t0, k;
        bit got_to, bad_rv, seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;

        // directed ops
        run_op("mulh_m2x3",   F_MULH,  32'hFFFF_FFFE, 32'd3, 35);
        run_op("div_m7d2",    F_DIV,   32'hFFFF_FFF9, 32'd2, 35);
        run_op("rem_m7d2",    F_REM,   32'hFFFF_FFF9, 32'd2, 35);
        run_op("mulhu_max",   F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        run_op("divu_by0",    F_DIVU,  32'd5, 32'd0, 1);
        run_op("remu_by0",    F_REMU,  32'd5, 32'd0, 1);
        run_op("div_ovf",     F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op("rem_ovf",     F_REM,   32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op("mul_neg",     F_MUL,   32'hFFFF_FFFD, 32'd7, 35);
        run_op("mulhsu_neg",  F_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 35);
        run_op("div_by0_s",   F_DIV,   32'hFFFF_FFF0, 32'd0, 1);
        run_op("rem_by0_s",   F_REM,   32'hFFFF_FFF0, 32'd0, 1);

        // random ops
        for (int i = 0; i < 6; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            run_op("random", rf, ra, rb, exp_latency(rf, ra, rb));
        end

        // kill in WAIT at T+10, then a new op waits for the drain
        op_valid = 1'b1; op_funct = F_DIVU; op_a = 32'd100; op_b = 32'd7;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("kill stall", 64'(stall), 64'd0);
        chk("kill in wait", 64'(dbg_state), 64'd2);
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        chk("drain state", 64'(dbg_state), 64'd4);
        chk("drain stall no op", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        run_op("after_drain", F_MUL, 32'd6, 32'd7, 58);

        // engine never answers: timeout
        eng_en = 1'b0;
        op_valid = 1'b1; op_funct = F_DIVU; op_a = 32'd9; op_b = 32'd2;
        got_to = 1'b0; bad_rv = 1'b0; k = 0;
        while (!got_to && (k < 200)) begin
            @(negedge clk);
            if (result_valid) bad_rv = 1'b1;
            if (timeout_err) begin
                got_to = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        chk("timeout seen", 64'(got_to), 64'd1);
        chk("timeout cycle", 64'(k), 64'(TIMEOUT + 2));
        chk("timeout no result", 64'(bad_rv), 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("timeout pulse width", 64'(timeout_err), 64'd0);
        chk("timeout stall drop", 64'(stall), 64'd0);
        chk("timeout to idle", 64'(dbg_state), 64'd0);
        eng_en = 1'b1;
        @(posedge clk);
        #1;

        // reset mid-WAIT
        op_valid = 1'b1; op_funct = F_MULHU; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_zero("rst_mid_wait");
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid || md_valid || timeout_err) seen = 1'b1;
        end
        chk("quiet after reset", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        run_op("post_reset", F_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 35);

        chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
